// File: rtl/switch_scheduler.sv
// -----------------------------------------------------------------------------
// switch_scheduler
//
// Output scheduler for the packet switch. Each round it reads the head packet
// of every input RAM and routes it to the output RAM write port named by the
// packet's destination field. Each output has its own round-robin arbiter, so
// two inputs never write the same output in the same round. Packets addressed
// to a port that does not exist are consumed and counted.
//
// Round timing (FSM IDLE -> FETCH -> ARB -> FETCH -> ARB ...):
//   FETCH : in_rden is high and in_rd_add is stable; the RAMs return the data.
//   ARB   : in_data is valid; arbitration runs and all results are registered.
//   The write pulse for a round is visible in the cycle after ARB.
//
// Handshake: there is no backpressure. The input RAM is a plain synchronous
// RAM (data valid one cycle after in_rden). The output RAM accepts a word
// whenever out_wr[o] is high for one cycle; out_data[o] is meaningful only in
// that cycle and otherwise holds its last written value.
//
// Ports:
//   clk        : clock, all logic on the rising edge
//   reset      : synchronous, active-high, dominant over every other input
//   enable     : scheduling enable, sampled only in IDLE and FETCH
//   in_data    : input RAM read data, port i at [i*DATA_W +: DATA_W]
//   in_wr_add  : input RAM write pointers (next free address), per port
//   in_rd_add  : input RAM read addresses, per port
//   in_rden    : input RAM read enables
//   out_wr     : output RAM write strobes, one-cycle pulses
//   out_data   : output RAM write data, port o at [o*DATA_W +: DATA_W]
//   drop_count : saturating count of packets with an invalid destination
//   busy       : high while in FETCH or ARB
//   state_dbg  : current FSM state (IDLE=0, FETCH=1, ARB=2), for debug
// -----------------------------------------------------------------------------
module switch_scheduler #(
    parameter int NUM_PORTS = 3,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 12,
    parameter int DEST_W    = 3,
    parameter int CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
    input  logic [NUM_PORTS*ADDR_W-1:0]   in_wr_add,
    output logic [NUM_PORTS*ADDR_W-1:0]   in_rd_add,
    output logic [NUM_PORTS-1:0]          in_rden,
    output logic [NUM_PORTS-1:0]          out_wr,
    output logic [NUM_PORTS*DATA_W-1:0]   out_data,
    output logic [CNT_W-1:0]              drop_count,
    output logic                          busy,
    output logic [1:0]                    state_dbg
);

    localparam int PTR_W  = $clog2(NUM_PORTS);
    localparam int DROP_W = $clog2(NUM_PORTS + 1);
    // Port count widened to DEST_W+1 bits so the range check cannot overflow.
    localparam logic [DEST_W:0] NUM_PORTS_D = (DEST_W + 1)'(NUM_PORTS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ARB   = 2'd2
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] rr_ptr [NUM_PORTS];

    assign state_dbg = state;

    // ------------------------------------------------------------------
    // Arbitration datapath (only its results in ARB are ever registered)
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] rd_ptr     [NUM_PORTS];
    logic [ADDR_W-1:0] rd_inc     [NUM_PORTS];
    logic [DATA_W-1:0] word       [NUM_PORTS];
    logic [DEST_W-1:0] dest       [NUM_PORTS];
    logic [NUM_PORTS-1:0] nonempty;
    logic [NUM_PORTS-1:0] invalid;
    logic [NUM_PORTS-1:0] consumed;
    logic [NUM_PORTS-1:0] grant;
    logic [DATA_W-1:0] grant_data [NUM_PORTS];
    logic [PTR_W-1:0]  rr_next    [NUM_PORTS];
    logic [DROP_W-1:0] drop_num;
    logic [CNT_W:0]    drop_sum;
    logic [CNT_W-1:0]  drop_next;

    always_comb begin
        int               idx;
        logic [PTR_W-1:0] sel;

        idx       = 0;
        sel       = '0;
        nonempty  = '0;
        invalid   = '0;
        consumed  = '0;
        grant     = '0;
        drop_num  = '0;

        for (int i = 0; i < NUM_PORTS; i++) begin
            rd_ptr[i] = in_rd_add[i*ADDR_W +: ADDR_W];
            rd_inc[i] = rd_ptr[i] + ADDR_W'(1);
            word[i]   = in_data[i*DATA_W +: DATA_W];
            dest[i]   = word[i][DEST_W-1:0];
            // Inequality (not less-than) keeps wrapped pointers working.
            nonempty[i] = (rd_ptr[i] != in_wr_add[i*ADDR_W +: ADDR_W]);
            invalid[i]  = nonempty[i] && ({1'b0, dest[i]} >= NUM_PORTS_D);
            consumed[i] = invalid[i];
            drop_num    = drop_num + DROP_W'(invalid[i]);
        end

        // Per output: first requester at or after rr_ptr, scanning circularly.
        // An input has exactly one destination, so it can win at most one
        // output per round.
        for (int o = 0; o < NUM_PORTS; o++) begin
            grant_data[o] = '0;
            rr_next[o]    = rr_ptr[o];
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = int'(rr_ptr[o]) + k;
                if (idx >= NUM_PORTS) begin
                    idx = idx - NUM_PORTS;
                end
                sel = PTR_W'(idx);
                if (!grant[o] && nonempty[sel] && (dest[sel] == DEST_W'(o))) begin
                    grant[o]      = 1'b1;
                    grant_data[o] = word[sel];
                    rr_next[o]    = (idx == NUM_PORTS - 1) ? '0 : PTR_W'(idx + 1);
                    consumed[sel] = 1'b1;
                end
            end
        end

        // Several inputs may drop in one round; the counter saturates.
        drop_sum  = {1'b0, drop_count} + (CNT_W + 1)'(drop_num);
        drop_next = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            in_rd_add  <= '0;
            in_rden    <= '0;
            out_wr     <= '0;
            out_data   <= '0;
            drop_count <= '0;
            busy       <= 1'b0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                rr_ptr[o] <= '0;
            end
        end else begin
            // Write strobes are single-cycle; only ARB raises them.
            out_wr <= '0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state   <= FETCH;
                        in_rden <= '1;
                        busy    <= 1'b1;
                    end else begin
                        in_rden <= '0;
                        busy    <= 1'b0;
                    end
                end

                FETCH: begin
                    in_rden <= '0;
                    if (enable) begin
                        state <= ARB;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                ARB: begin
                    // enable is ignored here so a round never completes partially.
                    state   <= FETCH;
                    in_rden <= '1;
                    busy    <= 1'b1;
                    for (int o = 0; o < NUM_PORTS; o++) begin
                        if (grant[o]) begin
                            out_wr[o]                      <= 1'b1;
                            out_data[o*DATA_W +: DATA_W]   <= grant_data[o];
                            rr_ptr[o]                      <= rr_next[o];
                        end
                    end
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        if (consumed[i]) begin
                            in_rd_add[i*ADDR_W +: ADDR_W] <= rd_inc[i];
                        end
                    end
                    drop_count <= drop_next;
                end

                default: begin
                    state   <= IDLE;
                    in_rden <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_scheduler.sv
// -----------------------------------------------------------------------------
// tb_switch_scheduler
//
// Directed bench for switch_scheduler (3 ports, 32-bit data, 12-bit addresses).
// The bench owns the input RAMs (array mem plus per-port write pointers) and
// emulates their one-cycle read latency. A packet-level model tracks, per
// round, which queue heads win which outputs and what every output must show;
// a negedge process compares the DUT against it each cycle. The main sequence
// adds hand-computed literal checks for the scenarios of interest.
// -----------------------------------------------------------------------------
module tb_switch_scheduler;

    localparam int N     = 3;
    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int DESTW = 3;
    localparam int CW    = 16;
    localparam int DEPTH = 1 << AW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    logic enable;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic [N*DW-1:0] in_data;
    logic [N*AW-1:0] in_wr_add;
    logic [N*AW-1:0] in_rd_add;
    logic [N-1:0]    in_rden;
    logic [N-1:0]    out_wr;
    logic [N*DW-1:0] out_data;
    logic [CW-1:0]   drop_count;
    logic            busy;
    logic [1:0]      state_dbg;

    switch_scheduler #(
        .NUM_PORTS (N),
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .DEST_W    (DESTW),
        .CNT_W     (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .in_data    (in_data),
        .in_wr_add  (in_wr_add),
        .in_rd_add  (in_rd_add),
        .in_rden    (in_rden),
        .out_wr     (out_wr),
        .out_data   (out_data),
        .drop_count (drop_count),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // ---------------- input RAM emulation ----------------
    logic [DW-1:0] mem    [N][DEPTH];
    logic [AW-1:0] wr_ptr [N];
    logic [DW-1:0] ram_q  [N];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (in_rden[i]) ram_q[i] <= mem[i][in_rd_add[i*AW +: AW]];
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            in_data[i*DW +: DW]   = ram_q[i];
            in_wr_add[i*AW +: AW] = wr_ptr[i];
        end
    end

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] od(input int o);
        return out_data[o*DW +: DW];
    endfunction

    function automatic logic [AW-1:0] rd(input int i);
        return in_rd_add[i*AW +: AW];
    endfunction

    // ---------------- packet-level model ----------------
    // m_phase: 0 = idle, 1 = reading queue heads, 2 = heads valid, arbitrate.
    int            m_phase;
    logic [AW-1:0] m_rd   [N];
    int            m_rr   [N];
    logic [CW-1:0] m_drop;
    logic [N-1:0]  m_wr;
    logic [DW-1:0] m_od   [N];
    bit            m_has  [N];
    logic [DW-1:0] m_pkt  [N];
    int            m_dst  [N];

    always @(posedge clk) begin
        m_wr = '0;
        if (reset) begin
            m_phase = 0;
            m_drop  = '0;
            for (int i = 0; i < N; i++) begin
                m_rd[i] = '0;
                m_rr[i] = 0;
                m_od[i] = '0;
            end
        end else begin
            case (m_phase)
                0: if (enable) m_phase = 1;
                1: m_phase = enable ? 2 : 0;
                default: begin
                    for (int i = 0; i < N; i++) begin
                        m_has[i] = (m_rd[i] != wr_ptr[i]);
                        m_pkt[i] = mem[i][m_rd[i]];
                        m_dst[i] = int'(m_pkt[i][DESTW-1:0]);
                    end
                    for (int i = 0; i < N; i++) begin
                        if (m_has[i] && m_dst[i] >= N) begin
                            if (m_drop != '1) m_drop = m_drop + 1'b1;
                            m_rd[i] = m_rd[i] + 1'b1;
                        end
                    end
                    for (int o = 0; o < N; o++) begin
                        for (int k = 0; k < N; k++) begin
                            int i;
                            i = (m_rr[o] + k) % N;
                            if (m_has[i] && m_dst[i] == o) begin
                                m_wr[o] = 1'b1;
                                m_od[o] = m_pkt[i];
                                m_rd[i] = m_rd[i] + 1'b1;
                                m_rr[o] = (i + 1) % N;
                                break;
                            end
                        end
                    end
                    m_phase = 1;
                end
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            check("out_wr", 64'(out_wr), 64'(m_wr));
            for (int o = 0; o < N; o++) check($sformatf("out_data[%0d]", o), 64'(od(o)), 64'(m_od[o]));
            for (int i = 0; i < N; i++) check($sformatf("in_rd_add[%0d]", i), 64'(rd(i)), 64'(m_rd[i]));
            check("drop_count", 64'(drop_count), 64'(m_drop));
            check("busy", 64'(busy), 64'(m_phase != 0));
            if (m_phase == 0) check("in_rden_idle", 64'(in_rden), 64'(0));
            if (m_phase == 1) check("in_rden_fetch", 64'(in_rden), 64'(3'b111));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < N; i++) wr_ptr[i] = '0;
        cycles(2);
        reset = 1'b0;
        cycles(1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < N; i++) begin
            wr_ptr[i] = '0;
            for (int a = 0; a < DEPTH; a++) mem[i][a] = '0;
        end

        // 1: reset with enable high, then FETCH right after release
        @(negedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        check("t1_out_wr", 64'(out_wr), 64'(0));
        check("t1_out_data", 64'(out_data), 64'(0));
        check("t1_rd_add", 64'(in_rd_add), 64'(0));
        check("t1_rden", 64'(in_rden), 64'(0));
        check("t1_drop", 64'(drop_count), 64'(0));
        check("t1_busy", 64'(busy), 64'(0));
        reset = 1'b0;
        cycles(1);
        check("t1_rden_fetch", 64'(in_rden), 64'(3'b111));
        check("t1_busy_fetch", 64'(busy), 64'(1));
        enable = 1'b0;
        cycles(4);

        // 2: single packet on input 1 to output 2
        mem[1][0] = 32'h0000_A502;
        wr_ptr[1] = 12'd1;
        enable = 1'b1;
        cycles(3);
        check("t2_out_wr", 64'(out_wr), 64'(3'b100));
        check("t2_out_data2", 64'(od(2)), 64'h0000_A502);
        check("t2_rd1", 64'(rd(1)), 64'(1));
        cycles(1);
        check("t2_no_more_wr", 64'(out_wr), 64'(0));
        enable = 1'b0;
        cycles(4);

        // 3: all inputs hold two packets for output 1 -> grants 0,1,2,0,1,2
        do_reset();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < 2; j++) mem[i][j] = 32'hC000_0001 + (i << 16) + (j << 8);
            wr_ptr[i] = 12'd2;
        end
        enable = 1'b1;
        cycles(3);
        for (int r = 0; r < 6; r++) begin
            if (r > 0) cycles(2);
            check($sformatf("t3_out_wr_r%0d", r), 64'(out_wr), 64'(3'b010));
            check($sformatf("t3_data_r%0d", r), 64'(od(1)),
                  64'(32'hC000_0001 + ((r % 3) << 16) + ((r / 3) << 8)));
        end
        for (int i = 0; i < N; i++) check($sformatf("t3_rd%0d", i), 64'(rd(i)), 64'(2));
        enable = 1'b0;
        cycles(4);

        // 4: destination 7 does not exist -> dropped
        mem[0][2] = 32'h0000_BEE7;
        wr_ptr[0] = 12'd3;
        enable = 1'b1;
        cycles(3);
        check("t4_out_wr", 64'(out_wr), 64'(0));
        check("t4_drop", 64'(drop_count), 64'(1));
        check("t4_rd0", 64'(rd(0)), 64'(3));
        enable = 1'b0;
        cycles(4);

        // 5: drain input 2 up to 4095, then two packets across the wrap
        for (int a = 2; a < DEPTH - 1; a++) mem[2][a] = 32'(a << 8);
        wr_ptr[2] = 12'd4095;
        enable = 1'b1;
        cycles(2 * 4093 + 6);
        enable = 1'b0;
        cycles(4);
        check("t5_rd2_pre", 64'(rd(2)), 64'(4095));
        mem[2][4095] = 32'h0000_5A00;
        mem[2][0]    = 32'h0000_5B00;
        wr_ptr[2]    = 12'd1;
        enable = 1'b1;
        cycles(3);
        check("t5_wr_a", 64'(out_wr), 64'(3'b001));
        check("t5_data_a", 64'(od(0)), 64'h0000_5A00);
        check("t5_rd2_a", 64'(rd(2)), 64'(0));
        cycles(2);
        check("t5_wr_b", 64'(out_wr), 64'(3'b001));
        check("t5_data_b", 64'(od(0)), 64'h0000_5B00);
        check("t5_rd2_b", 64'(rd(2)), 64'(1));
        enable = 1'b0;
        cycles(4);

        // 6: enable dropped during ARB, then reset during ARB
        for (int k = 0; k < 3; k++) begin
            mem[0][3 + k] = 32'h6000_0002 + (k << 8);
            mem[1][2 + k] = 32'h7000_0000 + (k << 8);
        end
        wr_ptr[0] = 12'd6;
        wr_ptr[1] = 12'd5;
        enable = 1'b1;
        cycles(2);
        enable = 1'b0;
        cycles(1);
        check("t6_out_wr", 64'(out_wr), 64'(3'b101));
        check("t6_data2", 64'(od(2)), 64'h6000_0002);
        check("t6_data0", 64'(od(0)), 64'h7000_0000);
        check("t6_rd0", 64'(rd(0)), 64'(4));
        check("t6_rd1", 64'(rd(1)), 64'(3));
        cycles(1);
        check("t6_busy_idle", 64'(busy), 64'(0));
        cycles(3);
        check("t6_no_wr", 64'(out_wr), 64'(0));
        check("t6_rd0_hold", 64'(rd(0)), 64'(4));
        enable = 1'b1;
        cycles(2);
        reset = 1'b1;
        cycles(1);
        check("t6_rst_out_wr", 64'(out_wr), 64'(0));
        check("t6_rst_rd", 64'(in_rd_add), 64'(0));
        check("t6_rst_busy", 64'(busy), 64'(0));
        check("t6_rst_drop", 64'(drop_count), 64'(0));
        reset  = 1'b0;
        enable = 1'b0;
        cycles(2);
        check("t6_rst_no_pulse", 64'(out_wr), 64'(0));
        cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/switch_scheduler.md
Name: switch_scheduler

Overview:
Parametrised N-port output scheduler for the packet switch. It reads packets from per-input RAM buffers and routes each packet to the output RAM write port selected by its destination field. Per-output round-robin arbitration prevents write collisions. It sits between the input packet RAMs (read side) and the output packet RAMs (write side), and it drops packets addressed to non-existent ports.

Parameters:
NUM_PORTS, 3, number of input and output ports (2..8)
DATA_W, 32, packet word width
ADDR_W, 12, input RAM address width; addresses wrap modulo 2^ADDR_W
DEST_W, 3, width of destination field in data[DEST_W-1:0]; must satisfy 2^DEST_W >= NUM_PORTS
CNT_W, 16, drop counter width

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous reset, active-high
enable  in  1  scheduling enable
in_data  in  NUM_PORTS*DATA_W  input RAM read data; port i at [i*DATA_W +: DATA_W]; valid 1 cycle after in_rden
in_wr_add  in  NUM_PORTS*ADDR_W  input RAM write pointers (next free address) per port
in_rd_add  out  NUM_PORTS*ADDR_W  input RAM read addresses per port
in_rden  out  NUM_PORTS  input RAM read enables
out_wr  out  NUM_PORTS  output RAM write strobes, 1-cycle pulse
out_data  out  NUM_PORTS*DATA_W  output RAM write data, valid when out_wr[o]=1
drop_count  out  CNT_W  count of packets dropped for invalid destination, saturating
busy  out  1  high in FETCH and ARB states

Behaviour:
- Reset (synchronous, dominant over every other input): state=IDLE; in_rd_add=0; in_rden=0; out_wr=0; out_data=0; drop_count=0; busy=0; every rr_ptr[o]=0.
- FSM states are IDLE, FETCH and ARB.
- IDLE:
  - in_rden=0.
  - Moves to FETCH when enable=1.
- FETCH:
  - in_rden set to all ones; in_rd_add held stable.
  - Moves to ARB when enable=1, otherwise to IDLE.
  - out_wr is low unless pulsing from the preceding ARB.
- ARB (RAM read data is valid in this state):
  - Per input i: nonempty_i = (in_rd_add_i != in_wr_add_i). Use inequality, not less-than, so pointer wrap-around works.
  - dest_i = in_data_i[DEST_W-1:0].
  - Invalid destination: if nonempty_i and dest_i >= NUM_PORTS, the packet is consumed. in_rd_add_i increments, no write is issued, and drop_count increments (holds at all ones).
  - Per output o, the requesters are inputs with nonempty_i and dest_i == o.
  - The grant goes to the first requester found scanning i = rr_ptr[o], rr_ptr[o]+1, ... modulo NUM_PORTS.
  - On a grant: out_wr[o]=1 and out_data[o]=in_data_g, both registered and visible the cycle after ARB. in_rd_add_g increments modulo 2^ADDR_W. rr_ptr[o] becomes (g+1) mod NUM_PORTS.
  - Ungranted requesters keep their address and retry the same packet in the next round.
  - At most one write per output per round; each input is granted at most once per round.
  - Always moves to FETCH.
- out_wr clears to 0 after a one-cycle pulse. out_data holds its last value when not written.
- Latency and throughput:
  - Packet present (rd!=wr) while in FETCH at cycle n: ARB at n+1, out_wr pulse at n+2.
  - Throughput is 1 packet per input per 2 cycles.
- enable deassert:
  - Sampled only in IDLE and FETCH.
  - An ARB in progress always completes, so no partial grants occur.
- Simultaneous events:
  - in_wr_add changing during ARB uses the value sampled that cycle.
  - A packet arriving in the same cycle is seen next round.
- Reset mid-ARB: pending grants are discarded, no out_wr pulse follows, and pointers return to 0.
- Full input buffer (wr wrapped to equal rd) reads as empty. Upstream must keep occupancy below 2^ADDR_W.

Test Plan:
1. Reset then idle: assert reset 2 cycles with enable=1 -> all outputs 0. After release, FETCH is on the next cycle and in_rden=3'b111.
2. Single packet: in_wr_add1=1, in_data1=32'h0000_A502 (dest 2), enable=1 -> out_wr=3'b100 and out_data[2]=32'h0000_A502 two cycles after FETCH. in_rd_add1=1; no further writes.
3. Collision round-robin: inputs 0, 1 and 2 each hold 2 packets, all with dest 1 -> out_wr[1] pulses once per round with grant order 0,1,2,0,1,2. All rd_add values end at 2; no out_wr[0] or out_wr[2].
4. Invalid destination: input 0 packet with data[2:0]=3'b111, NUM_PORTS=3 -> no out_wr, drop_count=1, in_rd_add0=1.
5. Wrap-around: preload in_rd_add2=4095 via prior traffic, set in_wr_add2=1, two packets with dest 0 -> two writes on output 0, in_rd_add2 ends at 1.
6. enable low mid-stream: drop enable during ARB -> that round's writes still occur, FSM goes FETCH->IDLE, and no further out_wr. Pulsing reset during the next ARB gives no pulse and in_rd_add=0.
